cci_mpf_prim_flit_tracker: RTL
==============================

CCI_MPF_PRIM_FLIT_TRACKER -- requirements
Module: cci_mpf_prim_flit_tracker

Interface
REQ-001 SHALL have parameter MAX_ACTIVE_REQS, default 128: number of trackable packet indices; power of 2, at least 2.
REQ-002 SHALL have parameter MAX_FLITS, default 4: maximum flits per packet; power of 2, at least 2; LEN_W = clog2(MAX_FLITS).
REQ-003 SHALL have parameter ALLOW_PACKED, default 1: when 0, rsp_is_packed is ignored and treated as 0.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 rdy  out  1  tracker initialised and accepting requests and responses.
REQ-007 req_en, req_idx, req_len  in  1, IDX_W=clog2(MAX_ACTIVE_REQS), LEN_W  new packet; req_len is encoded as flits minus 1.
REQ-008 rsp_en, rsp_idx, rsp_is_packed  in  1, IDX_W, 1  one response flit, or one packed whole-packet response.
REQ-009 T1_valid, T1_idx  out  1, IDX_W  registered copy of rsp_en and rsp_idx, one cycle after the response.
REQ-010 T1_pkt_sop, T1_pkt_eop  out  1, 1  the flit is the first / last of its packet.
REQ-011 T1_flit_num, T1_pkt_len  out  LEN_W, LEN_W  zero-based flit ordinal; packet length minus 1.
REQ-012 T1_err  out  1  protocol violation detected one cycle earlier.
REQ-013 active_cnt, idle  out  clog2(MAX_ACTIVE_REQS+1), 1  number of open packets; idle = (active_cnt == 0) and rdy.

Function
REQ-014 SHALL implement state machine INIT -> READY; INIT on reset; advances to READY after MAX_ACTIVE_REQS init cycles; rdy = 1 only in READY.
REQ-015 In INIT, an init counter SHALL walk index 0 to MAX_ACTIVE_REQS-1, clearing the valid bit and the flit count of each entry, one entry per cycle; req_en and rsp_en are ignored.
REQ-016 In READY, req_en SHALL store the length, set valid, and zero the count for req_idx at the same clock edge.
REQ-017 A response may reference an index from the cycle after its request; same-cycle request and response to one index SHALL flag T1_err and leave the entry unchanged by the response.
REQ-018 req_en to an already-valid index SHALL set T1_err in the following cycle, overwrite the length, and leave active_cnt unchanged.
REQ-019 rsp_en to an invalid index SHALL set T1_err and T1_valid, with T1_pkt_eop = 0, and SHALL NOT change any state.
REQ-020 For a non-packed response, the next-cycle outputs SHALL be:
- T1_flit_num = stored count
- T1_pkt_sop = (count == 0)
- T1_pkt_eop = (count == len)
REQ-021 On a non-packed response, the count SHALL increment, or clear together with the valid bit when eop.
REQ-022 A packed response, when ALLOW_PACKED = 1, SHALL produce:
- T1_pkt_sop = 1 only if count == 0, else T1_err = 1
- T1_pkt_eop = 1
- T1_flit_num = len
- the entry freed
REQ-023 Back-to-back responses to the same index SHALL observe the prior update with no bubble; flop-based tables are used, so no bypass path is needed.
REQ-024 active_cnt SHALL change as follows:
- +1 per new allocation
- -1 per eop
- unchanged when both occur in the same cycle
REQ-025 When T1_valid = 0, all T1 outputs other than T1_valid SHALL be 0, and T1_err SHALL be 0 unless REQ-018 fires.
REQ-026 Count arithmetic SHALL be LEN_W bits, unsigned; the count never exceeds len, so there is no wrap-around.

Reset
REQ-027 reset_n low SHALL immediately force:
- state to INIT and the init counter to 0
- rdy, T1_valid, T1_err, active_cnt, all T1 data to 0
REQ-028 Reset asserted mid-operation SHALL discard all open packets; after release, full INIT re-runs before rdy rises.
REQ-029 Table contents SHALL NOT require reset; INIT clears them.

Structure
REQ-030 The state enum (t_flit_trk_state) and the length/count typedef derived from MAX_FLITS SHALL live in the shared MPF primitives package.
REQ-031 The length/count table SHALL be one natural sub-module: cci_mpf_prim_flit_tracker_table, flop arrays with a synchronous write and a combinational read.

Verification
REQ-032 After reset release, rdy SHALL be 0 for exactly 128 cycles (default params), then 1; idle = 1.
REQ-033 req idx 5, len 3 (4 flits); 4 responses idx 5 -> flit_num 0,1,2,3; sop on first; eop on fourth only; active_cnt 1 -> 0.
REQ-034 req idx 7, len 3; packed response idx 7 -> eop = 1, sop = 1, flit_num = 3, T1_err = 0; second packed idx 7 -> T1_err = 1.
REQ-035 Same cycle: req idx 2 with eop response idx 9 (9 open, len 0) -> active_cnt unchanged; interleaved responses idx 2/9 are counted independently.
REQ-036 Response to unallocated idx 40 -> T1_err = 1, eop = 0; req to open idx 5 -> T1_err = 1.
REQ-037 reset_n pulsed with 3 packets open -> active_cnt = 0 at once; post-INIT response idx 5 -> T1_err = 1.

Source files
------------

// File: rtl/cci_mpf_prim_flit_tracker_pkg.sv
// Shared MPF primitive types for the flit tracker: controller states and the
// default packet length/count type.
package cci_mpf_prim_flit_tracker_pkg;

    typedef enum logic {
        FLIT_TRK_INIT  = 1'b0,
        FLIT_TRK_READY = 1'b1
    } t_flit_trk_state;

    localparam int unsigned MPF_FLIT_TRK_DEFAULT_MAX_FLITS = 4;

    // Length/count type for the default MAX_FLITS; holds (flits - 1).
    typedef logic [$clog2(MPF_FLIT_TRK_DEFAULT_MAX_FLITS)-1:0] t_flit_trk_len;

endpackage

// File: rtl/cci_mpf_prim_flit_tracker_table.sv
// Per-index valid/length/count storage: flop arrays, synchronous writes,
// combinational reads. Port A (alloc/init) wins over port B (response update).
module cci_mpf_prim_flit_tracker_table #(
    parameter  int unsigned N_ENTRIES = 128,
    parameter  int unsigned LEN_W     = 2,
    localparam int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic             clk,
    input  logic             i_wa_en,
    input  logic [IDX_W-1:0] i_wa_idx,
    input  logic             i_wa_valid,
    input  logic [LEN_W-1:0] i_wa_len,
    input  logic [LEN_W-1:0] i_wa_cnt,
    input  logic             i_wb_en,
    input  logic [IDX_W-1:0] i_wb_idx,
    input  logic             i_wb_valid,
    input  logic [LEN_W-1:0] i_wb_cnt,
    input  logic [IDX_W-1:0] i_ra_idx,
    output logic             o_ra_valid,
    output logic [LEN_W-1:0] o_ra_len,
    output logic [LEN_W-1:0] o_ra_cnt,
    input  logic [IDX_W-1:0] i_rb_idx,
    output logic             o_rb_valid
);

    logic             r_valid [N_ENTRIES];
    logic [LEN_W-1:0] r_len   [N_ENTRIES];
    logic [LEN_W-1:0] r_cnt   [N_ENTRIES];

    always_ff @(posedge clk) begin
        if (i_wb_en) begin
            r_valid[i_wb_idx] <= i_wb_valid;
            r_cnt[i_wb_idx]   <= i_wb_cnt;
        end
        if (i_wa_en) begin
            r_valid[i_wa_idx] <= i_wa_valid;
            r_len[i_wa_idx]   <= i_wa_len;
            r_cnt[i_wa_idx]   <= i_wa_cnt;
        end
    end

    assign o_ra_valid = r_valid[i_ra_idx];
    assign o_ra_len   = r_len[i_ra_idx];
    assign o_ra_cnt   = r_cnt[i_ra_idx];
    assign o_rb_valid = r_valid[i_rb_idx];

endmodule

// File: rtl/cci_mpf_prim_flit_tracker.sv
// Tracks flit position within multi-flit packets per request index and flags
// protocol violations; results are registered one cycle after the response.
module cci_mpf_prim_flit_tracker
    import cci_mpf_prim_flit_tracker_pkg::*;
#(
    parameter  int unsigned MAX_ACTIVE_REQS = 128,
    parameter  int unsigned MAX_FLITS       = MPF_FLIT_TRK_DEFAULT_MAX_FLITS,
    parameter  int unsigned ALLOW_PACKED    = 1,
    localparam int unsigned IDX_W           = $clog2(MAX_ACTIVE_REQS),
    localparam int unsigned LEN_W           = $clog2(MAX_FLITS),
    localparam int unsigned CNT_W           = $clog2(MAX_ACTIVE_REQS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             rdy,
    input  logic             req_en,
    input  logic [IDX_W-1:0] req_idx,
    input  logic [LEN_W-1:0] req_len,
    input  logic             rsp_en,
    input  logic [IDX_W-1:0] rsp_idx,
    input  logic             rsp_is_packed,
    output logic             T1_valid,
    output logic [IDX_W-1:0] T1_idx,
    output logic             T1_pkt_sop,
    output logic             T1_pkt_eop,
    output logic [LEN_W-1:0] T1_flit_num,
    output logic [LEN_W-1:0] T1_pkt_len,
    output logic             T1_err,
    output logic [CNT_W-1:0] active_cnt,
    output logic             idle
);

    t_flit_trk_state r_state, w_state_nxt;
    logic [IDX_W-1:0] r_init_idx;
    logic             w_rdy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= FLIT_TRK_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == FLIT_TRK_INIT) r_init_idx <= r_init_idx + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        case (r_state)
            FLIT_TRK_INIT:  if (r_init_idx == IDX_W'(MAX_ACTIVE_REQS - 1)) w_state_nxt = FLIT_TRK_READY;
            FLIT_TRK_READY: w_rdy = 1'b1;
            default:        w_state_nxt = FLIT_TRK_INIT;
        endcase
    end

    logic             w_rsp_tbl_valid, w_req_tbl_valid;
    logic [LEN_W-1:0] w_rsp_len, w_rsp_cnt;
    logic             w_wa_en, w_wa_valid, w_wb_en, w_wb_valid;
    logic [IDX_W-1:0] w_wa_idx;
    logic [LEN_W-1:0] w_wa_len, w_wb_cnt;

    cci_mpf_prim_flit_tracker_table #(
        .N_ENTRIES (MAX_ACTIVE_REQS),
        .LEN_W     (LEN_W)
    ) u_table (
        .clk        (clk),
        .i_wa_en    (w_wa_en),
        .i_wa_idx   (w_wa_idx),
        .i_wa_valid (w_wa_valid),
        .i_wa_len   (w_wa_len),
        .i_wa_cnt   ('0),
        .i_wb_en    (w_wb_en),
        .i_wb_idx   (rsp_idx),
        .i_wb_valid (w_wb_valid),
        .i_wb_cnt   (w_wb_cnt),
        .i_ra_idx   (rsp_idx),
        .o_ra_valid (w_rsp_tbl_valid),
        .o_ra_len   (w_rsp_len),
        .o_ra_cnt   (w_rsp_cnt),
        .i_rb_idx   (req_idx),
        .o_rb_valid (w_req_tbl_valid)
    );

    logic             w_req, w_rsp, w_packed, w_req_dup, w_rsp_hit, w_rsp_err;
    logic             w_t1_sop, w_t1_eop, w_t1_err, w_alloc, w_free;
    logic [LEN_W-1:0] w_t1_num, w_t1_len;

    always_comb begin
        w_req      = req_en & w_rdy;
        w_rsp      = rsp_en & w_rdy;
        w_packed   = rsp_is_packed & (ALLOW_PACKED != 0);
        w_req_dup  = w_req & w_req_tbl_valid;
        // A same-cycle request to the response's index takes the entry; the response is dropped.
        w_rsp_hit  = w_rsp & w_rsp_tbl_valid & ~(w_req && (req_idx == rsp_idx));
        w_rsp_err  = 1'b0;
        w_t1_sop   = 1'b0;
        w_t1_eop   = 1'b0;
        w_t1_num   = '0;
        w_t1_len   = '0;
        if (w_rsp_hit) begin
            w_t1_len = w_rsp_len;
            w_t1_sop = (w_rsp_cnt == '0);
            if (w_packed) begin
                w_t1_eop  = 1'b1;
                w_t1_num  = w_rsp_len;
                w_rsp_err = (w_rsp_cnt != '0);
            end else begin
                w_t1_eop = (w_rsp_cnt == w_rsp_len);
                w_t1_num = w_rsp_cnt;
            end
        end
        w_t1_err = w_req_dup | (w_rsp & ~w_rsp_hit) | w_rsp_err;

        if (!w_rdy) begin
            w_wa_en    = 1'b1;
            w_wa_idx   = r_init_idx;
            w_wa_valid = 1'b0;
            w_wa_len   = '0;
        end else begin
            w_wa_en    = w_req;
            w_wa_idx   = req_idx;
            w_wa_valid = 1'b1;
            w_wa_len   = req_len;
        end
        w_wb_en    = w_rsp_hit;
        w_wb_valid = ~w_t1_eop;
        w_wb_cnt   = w_t1_eop ? '0 : (w_rsp_cnt + LEN_W'(1));

        w_alloc = w_req & ~w_req_tbl_valid;
        w_free  = w_rsp_hit & w_t1_eop;
    end

    logic             r_t1_valid, r_t1_sop, r_t1_eop, r_t1_err;
    logic [IDX_W-1:0] r_t1_idx;
    logic [LEN_W-1:0] r_t1_num, r_t1_len;
    logic [CNT_W-1:0] r_active_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_t1_valid   <= 1'b0;
            r_t1_idx     <= '0;
            r_t1_sop     <= 1'b0;
            r_t1_eop     <= 1'b0;
            r_t1_num     <= '0;
            r_t1_len     <= '0;
            r_t1_err     <= 1'b0;
            r_active_cnt <= '0;
        end else begin
            r_t1_valid <= w_rsp;
            r_t1_idx   <= w_rsp ? rsp_idx : '0;
            r_t1_sop   <= w_t1_sop;
            r_t1_eop   <= w_t1_eop;
            r_t1_num   <= w_t1_num;
            r_t1_len   <= w_t1_len;
            r_t1_err   <= w_t1_err;
            case ({w_alloc, w_free})
                2'b10:   r_active_cnt <= r_active_cnt + CNT_W'(1);
                2'b01:   r_active_cnt <= r_active_cnt - CNT_W'(1);
                default: r_active_cnt <= r_active_cnt;
            endcase
        end
    end

    assign rdy         = w_rdy;
    assign T1_valid    = r_t1_valid;
    assign T1_idx      = r_t1_idx;
    assign T1_pkt_sop  = r_t1_sop;
    assign T1_pkt_eop  = r_t1_eop;
    assign T1_flit_num = r_t1_num;
    assign T1_pkt_len  = r_t1_len;
    assign T1_err      = r_t1_err;
    assign active_cnt  = r_active_cnt;
    assign idle        = (r_active_cnt == '0) & w_rdy;

endmodule
